// File: rtl/ref_sched_pkg.sv
// rtl/ref_sched_pkg.sv - shared refresh scheduler types and default constants
//
// Package ref_pkg: scheduler state encoding, debt counter width and the
// default refresh cadence constants (also consumed by RAM controller benches).
package ref_pkg;

  localparam int DEBT_W        = 3;
  localparam int INTERVAL_DEF  = 390;  // FCLK cycles per refresh tick (15.6 us at 25 MHz)
  localparam int MAX_DEBT_DEF  = 7;
  localparam int URG_LEVEL_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAZY   = 2'd1,
    URGENT = 2'd2,
    DRAIN  = 2'd3
  } ref_state_t;

endpackage

// File: rtl/ref_sched_prescaler.sv
// rtl/ref_sched_prescaler.sv - refresh-due tick prescaler
//
// Module ref_prescaler
//   clk   in  1  FCLK, rising edge
//   rst   in  1  asynchronous active-high reset
//   tick  out 1  high for the single cycle the count sits at INTERVAL-1
module ref_prescaler #(
  parameter int INTERVAL = ref_pkg::INTERVAL_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/ref_sched.sv
// rtl/ref_sched.sv - DRAM refresh scheduler (debt tracking, lazy/urgent requests)
//
// Module ref_sched
//   CLK        in  1       FSB clock (FCLK)
//   RES        in  1       asynchronous active-high reset
//   BACT       in  1       FSB bus cycle active
//   RAMCS      in  1       current FSB cycle targets RAM
//   RefAck     in  1       refresh-complete pulse from the RAM controller
//   RefReq     out 1       refresh request (level)
//   RefUrg     out 1       urgent refresh, controller must stall FSB RAM access
//   RefDebt    out DEBT_W  outstanding refresh count
//   RefOvf     out 1       sticky: tick arrived with debt already saturated
//   RefErr     out 1       sticky: ack arrived with no debt outstanding
//   RefUrgCnt  out 8       saturating count of URGENT entries (REF_STATS_EN only)
// Optional feature macro: REF_STATS_EN
module ref_sched
  import ref_pkg::*;
#(
  parameter int INTERVAL  = INTERVAL_DEF,
  parameter int MAX_DEBT  = MAX_DEBT_DEF,
  parameter int URG_LEVEL = URG_LEVEL_DEF
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              BACT,
  input  logic              RAMCS,
  input  logic              RefAck,
  output logic              RefReq,
  output logic              RefUrg,
  output logic [DEBT_W-1:0] RefDebt,
  output logic              RefOvf,
`ifdef REF_STATS_EN
  output logic              RefErr,
  output logic [7:0]        RefUrgCnt
`else
  output logic              RefErr
`endif
);

  localparam logic [DEBT_W-1:0] MAX_D = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] URG_D = DEBT_W'(URG_LEVEL);

  logic              tick;
  logic              armed;
  logic              ack;
  logic              inc;
  logic              dec;
  logic              ovf_set;
  logic              err_set;
  logic              busy;
  logic              req_nxt;
  logic              urg_nxt;
  logic [DEBT_W-1:0] debt;
  logic [DEBT_W-1:0] debt_nxt;
  ref_state_t        state;
  ref_state_t        state_nxt;

  ref_prescaler #(
    .INTERVAL(INTERVAL)
  ) u_prescaler (
    .clk (CLK),
    .rst (RES),
    .tick(tick)
  );

  // Reset can land in the middle of a refresh; the ack that completes it may
  // arrive on the first edge after release and must not count against debt.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign ack  = RefAck & armed;
  // Only a RAM-targeted bus cycle holds off a lazy refresh.
  assign busy = BACT & RAMCS;

  // Debt arithmetic; a coincident tick and ack cancel with no flag side effects.
  always_comb begin
    inc      = tick & ~ack;
    dec      = ack & ~tick;
    debt_nxt = debt;
    ovf_set  = 1'b0;
    err_set  = 1'b0;
    if (inc) begin
      if (debt == MAX_D) begin
        ovf_set = 1'b1;
      end else begin
        debt_nxt = debt + 1'b1;
      end
    end else if (dec) begin
      if (debt == '0) begin
        err_set = 1'b1;
      end else begin
        debt_nxt = debt - 1'b1;
      end
    end
  end

  // Transitions look at the post-update debt so state and RefDebt move together.
  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    urg_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (debt_nxt >= URG_D) begin
          state_nxt = URGENT;
        end else if (debt_nxt != '0) begin
          state_nxt = LAZY;
        end
      end
      LAZY: begin
        if (debt_nxt >= URG_D) begin
          state_nxt = URGENT;
        end else if (debt_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      URGENT: begin
        if (ack) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Hysteresis: keep draining below URG_LEVEL, re-escalate only on growth.
        if (debt_nxt == '0) begin
          state_nxt = IDLE;
        end else if (inc && (debt_nxt >= URG_D)) begin
          state_nxt = URGENT;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_nxt = ((state_nxt == LAZY) & ~busy) | (state_nxt == URGENT) | (state_nxt == DRAIN);
    urg_nxt = (state_nxt == URGENT);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state  <= IDLE;
      debt   <= '0;
      RefReq <= 1'b0;
      RefUrg <= 1'b0;
      RefOvf <= 1'b0;
      RefErr <= 1'b0;
    end else begin
      state  <= state_nxt;
      debt   <= debt_nxt;
      RefReq <= req_nxt;
      RefUrg <= urg_nxt;
      RefOvf <= RefOvf | ovf_set;
      RefErr <= RefErr | err_set;
    end
  end

  assign RefDebt = debt;

`ifdef REF_STATS_EN
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      RefUrgCnt <= 8'd0;
    end else if ((state_nxt == URGENT) && (state != URGENT) && (RefUrgCnt != 8'hFF)) begin
      RefUrgCnt <= RefUrgCnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/ref_sched.md
Name: ref_sched

Overview:
- DRAM refresh scheduler. It owns the refresh cadence for the shared DRAM array and drives the RefReq/RefUrg request pair into the RAM controller.
- A prescaler marks refresh-due ticks. Missed refreshes accumulate in a debt counter.
- Requests are issued opportunistically while the FSB is idle, and forcibly once the debt crosses a threshold.
- Sits between the FCLK clock domain and the RAM controller's refresh inputs, replacing the refresh logic in the counter block.

Parameters:
- INTERVAL, 390, FCLK cycles per refresh tick (15.6 us at 25 MHz).
- MAX_DEBT, 7, debt saturation value; sets debt counter width to 3 bits.
- URG_LEVEL, 4, debt at or above which the urgent state is entered.

Ports:
- CLK  in  1  FSB clock (FCLK); all logic on the rising edge.
- RES  in  1  asynchronous, active-high reset.
- BACT  in  1  FSB bus cycle active (from /AS detection).
- RAMCS  in  1  current FSB cycle targets RAM.
- RefAck  in  1  one-cycle pulse from the RAM controller when a refresh cycle completes.
- RefReq  out  1  refresh request to the RAM controller.
- RefUrg  out  1  urgent refresh; RAM controller must stall FSB RAM access to service it.
- RefDebt  out  3  current debt count.
- RefOvf  out  1  sticky flag: a tick arrived while debt was already MAX_DEBT.
- RefErr  out  1  sticky flag: RefAck arrived with debt 0.

Behaviour:
- Reset (async, RES=1):
  - prescaler=0, debt=0, state=IDLE.
  - RefReq=0, RefUrg=0, RefDebt=0, RefOvf=0, RefErr=0.
  - Reset may assert mid-refresh; a RefAck in the first cycle after release is ignored and does not set RefErr.
- Prescaler:
  - counts 0..INTERVAL-1 and wraps.
  - tick = 1 for the single cycle where the count is INTERVAL-1.
  - First tick occurs INTERVAL cycles after reset release.
- Debt update, registered, one cycle latency:
  - tick&!RefAck: debt+1, saturating at MAX_DEBT; if debt was already MAX_DEBT, set RefOvf.
  - RefAck&!tick: debt-1 if debt>0; if debt=0, debt stays 0 and RefErr is set.
  - tick&RefAck: debt unchanged; no flags set, even at MAX_DEBT or at 0.
- FSM states: IDLE, LAZY, URGENT, DRAIN. Transitions are evaluated on the next-debt value.
  - IDLE: debt=0 → LAZY when debt becomes ≥1.
  - LAZY: 1≤debt<URG_LEVEL → URGENT when debt reaches URG_LEVEL; → IDLE when debt returns to 0.
  - URGENT: → DRAIN on the first RefAck received in URGENT.
  - DRAIN: keep requesting until debt=0 (hysteresis), then → IDLE. A tick in DRAIN that raises debt to URG_LEVEL → URGENT.
- Outputs, all registered:
  - RefReq = LAZY & !BACT, or URGENT, or DRAIN.
    - In LAZY, RefReq deasserts the cycle after BACT rises, even if the RAM controller has not acked.
    - The RAM controller treats RefReq as level, not a handshake.
  - RefUrg = URGENT only.
  - RAMCS is used only to qualify LAZY: a non-RAM bus cycle (BACT&!RAMCS) still permits RefReq in LAZY.
  - RefDebt mirrors the debt register.
- Sticky flags RefOvf and RefErr clear only on reset.

Optional Feature:
- Macro: REF_STATS_EN.
- When defined:
  - adds output RefUrgCnt [7:0], a saturating count of IDLE/LAZY/DRAIN→URGENT entries.
  - resets to 0 and holds at 255.
- When undefined:
  - port and counter are absent.
  - all other behaviour is identical.

Decomposition:
- Shared package ref_pkg holds:
  - state enum (IDLE, LAZY, URGENT, DRAIN);
  - DEBT_W=3;
  - default INTERVAL, MAX_DEBT and URG_LEVEL constants, also used by the RAM controller testbench.
- One sub-module, ref_prescaler:
  - INTERVAL parameter;
  - outputs the tick pulse;
  - independently unit-testable.

Test Plan:
- Reset release, BACT=0, no ack for 390 cycles → tick at cycle 390, RefDebt=1, RefReq=1 at cycle 391, RefUrg=0.
- Debt=2, BACT held 1 with RAMCS=1 → RefReq=0. Drop BACT → RefReq=1 next cycle. Two RefAck pulses → debt 0, RefReq=0, state IDLE.
- No acks for 4 ticks → RefUrg=1 at debt 4 regardless of BACT. One ack → RefUrg=0, RefReq stays 1 (DRAIN) until debt 0, including while BACT=1.
- No acks for 8 ticks → debt saturates at 7, RefOvf=1 on the 8th tick and stays set after debt later drains to 0.
- RefAck coincident with tick at debt 3 → debt stays 3, no flags. Isolated RefAck at debt 0 → RefErr=1, debt 0.
- RES asserted mid-URGENT with debt 5 → all outputs 0 asynchronously. RefAck on the first post-reset cycle → RefErr stays 0. With REF_STATS_EN, RefUrgCnt=0 after reset and increments once per URGENT entry.
